// File: rtl/serial_rx.sv
// ---------------------------------------------------------------------------
// serial_rx : UART receiver, 16x oversampled, LSB first.
//
// Frame: start bit, TRANSBIT data bits, optional parity bit, STOPBIT stop bits.
// A finished word is held on a valid/ready handshake together with its
// parity and framing status. A word that completes while the previous word
// is still held is dropped, and the sticky overrun flag is raised.
//
// Ports:
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   rx_in       serial line, idles high, asynchronous to clk
//   rx_data     received word
//   rx_valid    rx_data and the status flags are valid
//   rx_ready    consumer takes the word when rx_valid && rx_ready
//   parity_err  parity mismatch on the held word
//   frame_err   a stop bit was sampled low on the held word
//   rx_overrun  a frame was dropped because the held word was not taken
//   rx_busy     a frame is being received
// ---------------------------------------------------------------------------
module serial_rx #(
    parameter int CLK_FREQ    = 100000000,
    parameter int BAUD        = 9600,
    parameter int TRANSBIT    = 8,
    parameter int STOPBIT     = 2,
    parameter int PARITY_MODE = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                rx_in,
    output logic [TRANSBIT-1:0] rx_data,
    output logic                rx_valid,
    input  logic                rx_ready,
    output logic                parity_err,
    output logic                frame_err,
    output logic                rx_overrun,
    output logic                rx_busy
);

    localparam int          DIV       = CLK_FREQ / (BAUD * 16);
    localparam logic [15:0] DIV_LAST  = 16'(DIV - 1);
    localparam logic [2:0]  LAST_BIT  = 3'(TRANSBIT - 1);
    localparam logic        LAST_STOP = 1'(STOPBIT - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;

    state_e state_q, state_d;

    logic                rx_meta_q, rxs_q;
    logic [15:0]         div_cnt_q;
    logic [3:0]          samp_cnt_q;
    logic [2:0]          bit_cnt_q;
    logic                stop_cnt_q;
    logic [TRANSBIT-1:0] shift_q;
    logic                par_err_q, frm_err_q;
    logic                armed_q;
    logic [TRANSBIT-1:0] rx_data_q;
    logic                rx_valid_q, parity_err_q, frame_err_q, overrun_q;

    logic tick, mid, start_det, frame_done, exp_par, handshake;

    // Two-flop synchroniser; reset to the idle line level so no false start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rxs_q     <= 1'b1;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // flop samples the pre-edge value of its neighbours.
            rx_meta_q <= rx_in;
            rxs_q     <= rx_meta_q;
        end
    end

    assign tick = (div_cnt_q == DIV_LAST);
    // Every sample (start check, data, parity, stop) lands on count 7.
    assign mid  = tick && (samp_cnt_q == 4'd7);

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        // NOTE: default first so every path assigns state_d and no latch forms.
        state_d = state_q;
        case (state_q)
            IDLE:   if (armed_q && !rxs_q) state_d = START;
            START:  if (mid) state_d = rxs_q ? IDLE : DATA;
            DATA:   if (mid && bit_cnt_q == LAST_BIT)
                        state_d = (PARITY_MODE == 0) ? STOP : PARITY;
            PARITY: if (mid) state_d = STOP;
            STOP:   if (mid && stop_cnt_q == LAST_STOP) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        rx_busy    = (state_q != IDLE);
        start_det  = (state_q == IDLE) && armed_q && !rxs_q;
        frame_done = (state_q == STOP) && mid && (stop_cnt_q == LAST_STOP);
    end

    always_comb begin
        exp_par = 1'b0;
        case (PARITY_MODE)
            1:       exp_par = ^shift_q;
            2:       exp_par = ~^shift_q;
            3:       exp_par = 1'b1;
            default: exp_par = 1'b0;
        endcase
    end

    // Baud tick divider and per-bit counters; both realign on start detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_q  <= '0;
            samp_cnt_q <= '0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            shift_q    <= '0;
            par_err_q  <= 1'b0;
            frm_err_q  <= 1'b0;
            armed_q    <= 1'b0;
        end else begin
            if (start_det || tick) div_cnt_q <= '0;
            else                   div_cnt_q <= div_cnt_q + 16'd1;

            if (start_det) samp_cnt_q <= '0;
            else if (tick) samp_cnt_q <= samp_cnt_q + 4'd1;

            // Arming needs a high line in IDLE; a held-low break stays disarmed.
            if (state_q == IDLE && rxs_q) armed_q <= 1'b1;
            else if (start_det)           armed_q <= 1'b0;
            else if (frame_done)          armed_q <= rxs_q;

            if (start_det) begin
                bit_cnt_q  <= '0;
                stop_cnt_q <= 1'b0;
                par_err_q  <= 1'b0;
                frm_err_q  <= 1'b0;
            end else if (mid) begin
                case (state_q)
                    DATA: begin
                        shift_q   <= {rxs_q, shift_q[TRANSBIT-1:1]};
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                    end
                    PARITY: par_err_q <= (rxs_q != exp_par);
                    STOP: begin
                        stop_cnt_q <= ~stop_cnt_q;
                        if (!rxs_q) frm_err_q <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Output holding register and handshake.
    assign handshake = rx_valid_q && rx_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
        end else if (frame_done && (!rx_valid_q || handshake)) begin
            // Slot is free (or freed this cycle): load the new word.
            rx_data_q    <= shift_q;
            rx_valid_q   <= 1'b1;
            parity_err_q <= par_err_q;
            frame_err_q  <= frm_err_q | ~rxs_q;   // include the final stop sample
            if (handshake) overrun_q <= 1'b0;
        end else if (frame_done) begin
            overrun_q <= 1'b1;                      // held word not taken: drop
        end else if (handshake) begin
            rx_valid_q <= 1'b0;
            overrun_q  <= 1'b0;
        end
    end

    assign rx_data    = rx_data_q;
    assign rx_valid   = rx_valid_q;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;
    assign rx_overrun = overrun_q;

endmodule

// File: doc/serial_rx.md
Name: serial_rx

Overview:
UART receiver that pairs with the team's serial transmitter; together they form the serial I/O device. It deserialises an asynchronous, LSB-first line into parallel bytes using 16x oversampling from the system clock. Received words are presented on a valid/ready handshake matching the transmitter's, together with parity, framing and overrun status. The frame format is fixed by parameters: start bit, data bits, optional parity bit, stop bits.

Parameters:
CLK_FREQ, 100000000, system clock frequency in Hz.
BAUD, 9600, line rate in bits per second.
TRANSBIT, 8, data bits per frame (1..8).
STOPBIT, 2, stop bits per frame (1..2).
PARITY_MODE, 2, parity bit: 0 none, 1 even, 2 odd, 3 mark, 4 space.

Ports:
clk  input  1  system clock, all logic on its rising edge.
rst_n  input  1  asynchronous active-low reset.
rx_in  input  1  serial line; idles high; asynchronous to clk.
rx_data  output  TRANSBIT  received word, LSB first on the line.
rx_valid  output  1  rx_data and status flags are valid.
rx_ready  input  1  consumer accepts the word when rx_valid && rx_ready.
parity_err  output  1  parity mismatch on the held word.
frame_err  output  1  one or more stop bits sampled low on the held word.
rx_overrun  output  1  a frame was dropped because the held word was not consumed.
rx_busy  output  1  a frame is being received (state is not IDLE).

Behaviour:
- Interface: one clock, clk. Reset is rst_n, asynchronous and active-low.
- Reset (async, rst_n=0): rx_data=0, rx_valid=0, parity_err=0, frame_err=0, rx_overrun=0, rx_busy=0. Synchroniser flops reset to 1. FSM goes to IDLE; all counters clear.
- Synchroniser: rx_in passes through 2 flops. All decisions use the second flop (rxs).
- Tick: divider DIV = CLK_FREQ/(BAUD*16), truncated; DIV must be at least 1. A 16-bit counter emits a 1-cycle tick every DIV clocks. The counter is free-running and restarts at 0 on start detection.
- Per bit: a 4-bit tick counter counts 0..15. A bit is sampled on the tick where the count is 7 (mid-bit). The bit ends at count 15.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: arms only after rxs=1 has been seen. On an armed 1->0 transition of rxs, go to START and clear the counters.
- START: at the mid-bit sample, rxs=0 moves to DATA; rxs=1 is a glitch and returns to IDLE with no output.
- DATA: sample TRANSBIT bits, one per 16 ticks, shifting LSB first. Then go to PARITY, or to STOP if PARITY_MODE=0.
- PARITY: expected bit is: even = ^data; odd = ~^data; mark = 1; space = 0. Mismatch sets a pending parity error.
- STOP: sample STOPBIT bits. Any stop sample of 0 sets a pending frame error.
- Completion: on the mid-sample of the last stop bit, the FSM returns to IDLE immediately. This lets a start bit that directly follows be caught. IDLE is disarmed if that sample was 0.
- Delivery: completion is cycle C. At C+1, rx_valid=1 and rx_data, parity_err and frame_err are loaded together.
- A frame with an error is still delivered, with its flag set.
- Handshake: rx_valid stays high and rx_data/flags stay stable until a cycle with rx_valid && rx_ready. rx_valid clears at the following edge.
- Overrun: a frame completes while rx_valid=1 and no handshake occurs that cycle. The new frame is discarded, rx_data is unchanged, and rx_overrun=1 (sticky).
- rx_overrun clears on the next handshake, unless another overrun occurs in that same cycle.
- Simultaneous events: if a handshake and a delivery land in the same cycle, the new word loads, rx_valid stays 1 and no overrun is flagged.
- Break: a line held low delivers a frame with frame_err=1. No further frames are accepted until rxs returns high and falls again.
- Reset mid-frame: the partial frame is lost and there is no output. The next full frame after rst_n rises is received normally.

Test Plan:
Bench settings for all scenarios: CLK_FREQ=1536000, BAUD=9600 (DIV=10, 160 clocks/bit), defaults otherwise, rx_ready=1 unless stated.
1. Send 0xA5, parity bit 1, stop bits 11 -> rx_data=0xA5 and rx_valid high for exactly 1 cycle, starting 1 cycle after the last stop mid-sample. parity_err=0, frame_err=0. rx_busy low after completion.
2. Send 0x3C with parity bit 0 (correct is 1) -> rx_data=0x3C, parity_err=1, frame_err=0. Then 0x3D with parity 0 -> parity_err=0.
3. Send 0x81 with first stop bit 0 -> frame_err=1. Then hold the line low for 20 bit times -> no further rx_valid until the line goes high then low.
4. Pulse rx_in low for 5 clocks -> the start check fails; rx_busy pulses, then returns to 0, and rx_valid is never asserted.
5. Hold rx_ready=0 and send 0x11 then 0x22 back-to-back -> rx_data stays 0x11 and rx_overrun=1. Raise rx_ready for 1 cycle -> rx_valid=0 and rx_overrun=0 next cycle.
6. Drop rst_n during data bit 3 of 0x77 -> all outputs 0 immediately. Release and send 0x5A -> rx_data=0x5A with no error flags.
